// File: rtl/eis_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : eis_div_unit
//  Description : Sequential signed divider for the EIS DIV instruction.
//                A 2*WIDTH-bit signed dividend is divided by a WIDTH-bit
//                signed divisor, one quotient bit per clock. The core is a
//                restoring divider on magnitudes, followed by sign fix-up
//                and overflow detection. It produces the quotient, the
//                remainder, the N/Z/V/C flags and a write-back enable.
//  Revision    : 1.0 - initial release
// ============================================================================
module eis_div_unit #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [2*WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]     divisor,
    output logic                 ready,
    output logic                 done,
    output logic [WIDTH-1:0]     quotient,
    output logic [WIDTH-1:0]     remainder,
    output logic                 wb_en,
    output logic                 cc_n,
    output logic                 cc_z,
    output logic                 cc_v,
    output logic                 cc_c
);

    localparam int               c_CNT_W    = $clog2(WIDTH + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_INIT = c_CNT_W'(WIDTH);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    // Magnitude of the most negative W-bit value (2^(W-1))
    localparam logic [WIDTH-1:0] c_MIN_MAG  = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_PREP   = 2'd1,
        S_DIVIDE = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t                 r_state;
    logic [2*WIDTH-1:0]     r_dd;        // latched dividend
    logic [WIDTH-1:0]       r_ds;        // latched divisor
    logic [WIDTH:0]         r_pr;        // partial remainder
    logic [WIDTH-1:0]       r_lo;        // dividend low half, becomes quotient
    logic [WIDTH-1:0]       r_mds;       // divisor magnitude
    logic                   r_neg_q;
    logic                   r_neg_r;
    logic                   r_err_dz;
    logic                   r_err_ov;
    logic [c_CNT_W-1:0]     r_cnt;
    logic                   r_ready;
    logic                   r_done;
    logic [WIDTH-1:0]       r_q;
    logic [WIDTH-1:0]       r_r;
    logic                   r_wb;
    logic                   r_n;
    logic                   r_z;
    logic                   r_v;
    logic                   r_c;

    logic [2*WIDTH-1:0]     w_mag_dd;
    logic [WIDTH-1:0]       w_mag_ds;
    logic                   w_ds_zero;
    logic                   w_early_ov;
    logic [WIDTH:0]         w_pr_sh;
    logic [WIDTH:0]         w_mds_ext;
    logic                   w_ge;
    logic [WIDTH:0]         w_pr_sub;
    logic [WIDTH-1:0]       w_uq;
    logic [WIDTH-1:0]       w_ur;
    logic [WIDTH-1:0]       w_q_s;
    logic [WIDTH-1:0]       w_r_s;
    logic                   w_late_ov;

    // Operand magnitudes; the most negative dividend maps to 2^(2W-1) unsigned
    assign w_mag_dd   = r_dd[2*WIDTH-1] ? -r_dd : r_dd;
    assign w_mag_ds   = r_ds[WIDTH-1]   ? -r_ds : r_ds;
    assign w_ds_zero  = (r_ds == '0);
    // Quotient cannot fit in W unsigned bits when the high half already reaches the divisor
    assign w_early_ov = !w_ds_zero && (w_mag_dd[2*WIDTH-1:WIDTH] >= w_mag_ds);

    // Restoring step: shift {pr, lo} left by one and trial-subtract the divisor.
    // A carry out of the partial remainder means it is certainly >= divisor.
    assign w_pr_sh    = {r_pr[WIDTH-1:0], r_lo[WIDTH-1]};
    assign w_mds_ext  = {1'b0, r_mds};
    assign w_ge       = r_pr[WIDTH] || (w_pr_sh >= w_mds_ext);
    assign w_pr_sub   = w_pr_sh - w_mds_ext;

    // Sign fix-up and signed range check on the unsigned result
    assign w_uq       = r_lo;
    assign w_ur       = r_pr[WIDTH-1:0];
    assign w_q_s      = r_neg_q ? -w_uq : w_uq;
    assign w_r_s      = r_neg_r ? -w_ur : w_ur;
    assign w_late_ov  = r_neg_q ? (w_uq > c_MIN_MAG) : w_uq[WIDTH-1];

    // Control FSM with datapath and registered results
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_dd     <= '0;
            r_ds     <= '0;
            r_pr     <= '0;
            r_lo     <= '0;
            r_mds    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_err_dz <= 1'b0;
            r_err_ov <= 1'b0;
            r_cnt    <= '0;
            r_ready  <= 1'b1;
            r_done   <= 1'b0;
            r_q      <= '0;
            r_r      <= '0;
            r_wb     <= 1'b0;
            r_n      <= 1'b0;
            r_z      <= 1'b0;
            r_v      <= 1'b0;
            r_c      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_dd    <= dividend;
                        r_ds    <= divisor;
                        r_ready <= 1'b0;
                        r_state <= S_PREP;
                    end
                end
                S_PREP: begin
                    r_mds    <= w_mag_ds;
                    r_neg_q  <= r_dd[2*WIDTH-1] ^ r_ds[WIDTH-1];
                    r_neg_r  <= r_dd[2*WIDTH-1];
                    r_pr     <= {1'b0, w_mag_dd[2*WIDTH-1:WIDTH]};
                    r_lo     <= w_mag_dd[WIDTH-1:0];
                    r_cnt    <= c_CNT_INIT;
                    r_err_dz <= w_ds_zero;
                    r_err_ov <= w_early_ov;
                    if (w_ds_zero || w_early_ov) begin
                        r_state <= S_FINISH;
                    end else begin
                        r_state <= S_DIVIDE;
                    end
                end
                S_DIVIDE: begin
                    r_pr  <= w_ge ? w_pr_sub : w_pr_sh;
                    r_lo  <= {r_lo[WIDTH-2:0], w_ge};
                    r_cnt <= r_cnt - c_CNT_ONE;
                    if (r_cnt == c_CNT_ONE) begin
                        r_state <= S_FINISH;
                    end
                end
                S_FINISH: begin
                    r_done  <= 1'b1;
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                    if (r_err_dz) begin
                        r_q  <= '0;
                        r_r  <= '0;
                        r_wb <= 1'b0;
                        r_n  <= 1'b0;
                        r_z  <= 1'b0;
                        r_v  <= 1'b1;
                        r_c  <= 1'b1;
                    end else if (r_err_ov || w_late_ov) begin
                        r_q  <= '0;
                        r_r  <= '0;
                        r_wb <= 1'b0;
                        r_n  <= 1'b0;
                        r_z  <= 1'b0;
                        r_v  <= 1'b1;
                        r_c  <= 1'b0;
                    end else begin
                        r_q  <= w_q_s;
                        r_r  <= w_r_s;
                        r_wb <= 1'b1;
                        r_n  <= w_q_s[WIDTH-1];
                        r_z  <= (w_q_s == '0);
                        r_v  <= 1'b0;
                        r_c  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign ready     = r_ready;
    assign done      = r_done;
    assign quotient  = r_q;
    assign remainder = r_r;
    assign wb_en     = r_wb;
    assign cc_n      = r_n;
    assign cc_z      = r_z;
    assign cc_v      = r_v;
    assign cc_c      = r_c;

endmodule
`default_nettype wire

// File: tb/tb_eis_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_eis_div_unit
//  Description : Scoreboard bench for eis_div_unit. The driver pushes the
//                expected result of every accepted operation, computed with
//                plain signed arithmetic; a monitor pops and compares on done.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_eis_div_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [31:0] dividend;
    logic [15:0] divisor;
    logic        ready;
    logic        done;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        wb_en;
    logic        cc_n;
    logic        cc_z;
    logic        cc_v;
    logic        cc_c;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [15:0] q;
        logic [15:0] r;
        logic        wb;
        logic        n;
        logic        z;
        logic        v;
        logic        c;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    eis_div_unit #(.WIDTH(16)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .ready     (ready),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .wb_en     (wb_en),
        .cc_n      (cc_n),
        .cc_z      (cc_z),
        .cc_v      (cc_v),
        .cc_c      (cc_c)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: signed division with truncation toward zero; remainder takes dividend sign
    function automatic exp_t model(input logic [31:0] dd, input logic [15:0] ds, input int acc);
        exp_t   e;
        longint sdd, sds, mdd, mds, q, r;
        e.q = '0; e.r = '0; e.wb = 1'b0; e.n = 1'b0; e.z = 1'b0; e.v = 1'b0; e.c = 1'b0;
        e.acc = acc;
        sdd = longint'($signed(dd));
        sds = longint'($signed(ds));
        if (sds == 0) begin
            e.v   = 1'b1;
            e.c   = 1'b1;
            e.lat = 2;
        end else begin
            mdd   = (sdd < 0) ? -sdd : sdd;
            mds   = (sds < 0) ? -sds : sds;
            e.lat = ((mdd >> 16) >= mds) ? 2 : 18;
            q = sdd / sds;
            r = sdd % sds;
            if (q > 32767 || q < -32768) begin
                e.v = 1'b1;
            end else begin
                e.q  = q[15:0];
                e.r  = r[15:0];
                e.wb = 1'b1;
                e.n  = (q < 0);
                e.z  = (q == 0);
            end
        end
        return e;
    endfunction

    // Present an operation and wait for its accept edge
    task automatic issue(input logic [31:0] dd, input logic [15:0] ds,
                         input bit expect_it, input bit keep, output int acc);
        int n;
        n = 0;
        dividend = dd;
        divisor  = ds;
        start    = 1'b1;
        while (ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (ready !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: ready=%b required 1", ready);
            start = 1'b0;
            acc   = -1;
        end else begin
            @(posedge clk);
            #1;
            acc = cyc;
            if (expect_it) sb.push_back(model(dd, ds, acc));
            if (!keep) start = 1'b0;
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding operation
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: done=1 required 0 (nothing outstanding)");
            end else begin
                mon_e = sb.pop_front();
                check("result {q,r,wb,nzvc}",
                      {quotient, remainder, wb_en, cc_n, cc_z, cc_v, cc_c},
                      {mon_e.q, mon_e.r, mon_e.wb, mon_e.n, mon_e.z, mon_e.v, mon_e.c});
                check("latency", 64'(cyc - mon_e.acc), 64'(mon_e.lat));
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d_dd [9];
        logic [15:0] d_ds [9];
        int          a1, a2, n;
        logic [15:0] x16;
        logic [31:0] t;

        d_dd = '{32'd100, 32'hFFFFFF9C, 32'd100, 32'd1234, 32'h00010000,
                 32'd32768, 32'hFFFF8000, 32'd0, 32'd6};
        d_ds = '{16'd7, 16'd7, 16'hFFF9, 16'd0, 16'd1,
                 16'd1, 16'd1, 16'd5, 16'hFFFD};

        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        reset_n  = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_ready", 64'(ready), 64'd1);
        check("reset_outputs", {done, wb_en, quotient, remainder, cc_n, cc_z, cc_v, cc_c}, 64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // First divide with ready watched through the busy window
        issue(32'd100, 16'd7, 1'b1, 1'b0, a1);
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            check("busy_ready", 64'(ready), 64'd0);
        end
        @(negedge clk);
        check("ready_after_finish", 64'(ready), 64'd1);

        // Directed cases
        for (int i = 0; i < 9; i++) begin
            issue(d_dd[i], d_ds[i], 1'b1, 1'b0, a1);
        end

        // Back-to-back with start held: no idle bubble
        issue(32'd100, 16'd7, 1'b1, 1'b1, a1);
        issue(32'hFFFFFF9C, 16'd7, 1'b1, 1'b0, a2);
        check("b2b_gap_normal", 64'(a2 - a1), 64'd19);
        issue(32'd1234, 16'd0, 1'b1, 1'b1, a1);
        issue(32'd6, 16'hFFFD, 1'b1, 1'b0, a2);
        check("b2b_gap_dz", 64'(a2 - a1), 64'd3);

        // A start pulse during a divide must be ignored
        issue(32'd100, 16'd7, 1'b1, 1'b0, a1);
        repeat (4) @(posedge clk);
        #1;
        dividend = 32'h00012345;
        divisor  = 16'd3;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;

        // Reset in the middle of a divide abandons it
        issue(32'h00001000, 16'd3, 1'b0, 1'b0, a1);
        repeat (8) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midreset_ready", 64'(ready), 64'd1);
        check("midreset_outputs", {done, wb_en, quotient, remainder, cc_n, cc_z, cc_v, cc_c}, 64'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        issue(32'd100, 16'd7, 1'b1, 1'b0, a1);

        // Randomized operations
        for (int i = 0; i < 150; i++) begin
            int mode;
            mode = $urandom_range(0, 9);
            t    = $urandom;
            x16  = 16'($urandom);
            if (mode == 0) begin
                x16 = 16'd0;
            end else if (mode <= 6) begin
                t = {{16{x16[15]}}, x16};
                t = t << $urandom_range(0, 15);
                x16 = 16'($urandom);
            end else if (mode <= 8) begin
                x16 = 16'($urandom_range(1, 9));
                if ($urandom_range(0, 1) == 1) x16 = -x16;
            end
            issue(t, x16, 1'b1, ($urandom_range(0, 3) == 0), a1);
        end
        start = 1'b0;

        // Drain the scoreboard
        n = 0;
        while (sb.size() > 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: outstanding=%0d required 0", sb.size());
        end
        repeat (5) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
